// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control unit, a Moore FSM that sequences the datapath enables
// plus the ALU decoder that turns op/funct into the 3-bit ALU function select.
module multicycle_controller #(
   parameter bit EXT_OPS = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic       w_irwrite;
   logic       w_regwrite;
   logic       w_memwrite;
   logic       w_pcwrite;
   logic       w_branch;
   logic [1:0] w_aluop;
   logic [2:0] w_funct_ctl;

   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:   w_next = S_DECODE;
         S_DECODE:
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_RTYPEEX;
               OP_BEQ:       w_next = S_BEQEX;
               OP_ADDI:      w_next = EXT_OPS ? S_ADDIEX : S_FETCH;
               OP_J:         w_next = EXT_OPS ? S_JEX : S_FETCH;
               default:      w_next = S_FETCH;
            endcase
         S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   w_next = S_MEMWB;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         default:   w_next = S_FETCH;
      endcase
   end

   always_comb begin
      iord       = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      w_regwrite = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_aluop    = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
            alusrcb   = 2'b01;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB: begin
            w_regwrite = 1'b1;
            memtoreg   = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            w_memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            w_aluop = 2'b10;
         end
         S_RTYPEWB: begin
            w_regwrite = 1'b1;
            regdst     = 1'b1;
         end
         S_BEQEX: begin
            alusrca  = 1'b1;
            w_aluop  = 2'b01;
            w_branch = 1'b1;
            pcsrc    = 2'b01;
         end
         S_ADDIWB:  w_regwrite = 1'b1;
         S_JEX: begin
            w_pcwrite = 1'b1;
            pcsrc     = 2'b10;
         end
         default: ;
      endcase
   end

   // unknown funct codes fall back to add so the ALU select is never X
   always_comb begin
      w_funct_ctl = funct == 6'b100010 ? 3'b110 :
                    funct == 6'b100100 ? 3'b000 :
                    funct == 6'b100101 ? 3'b001 :
                    funct == 6'b101010 ? 3'b111 : 3'b010;
      alucontrol  = w_aluop == 2'b01 ? 3'b110 :
                    w_aluop == 2'b10 ? w_funct_ctl : 3'b010;
   end

   // state-changing enables are held off for the whole time reset is high
   assign irwrite  = w_irwrite & ~reset;
   assign regwrite = w_regwrite & ~reset;
   assign memwrite = w_memwrite & ~reset;
   assign pcen     = ~reset & (w_pcwrite | (w_branch & zero));
   assign state    = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked every cycle against an
// instruction-path model, plus literal state/ALU-select histories.
module tb_multicycle_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op, funct;
   logic       zero;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic       x_iord, x_memwrite, x_irwrite, x_regdst, x_memtoreg, x_regwrite, x_alusrca, x_pcen;
   logic [1:0] x_alusrcb, x_pcsrc;
   logic [2:0] x_alucontrol;
   logic [3:0] x_state;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] m_st = 4'd0;
   logic [3:0] path[$];
   logic [31:0] sh, ah, ph, wh, xh, xw;

   always #5 clk = ~clk;

   multicycle_controller #(.EXT_OPS(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .state(state));

   multicycle_controller #(.EXT_OPS(1'b0)) dut_noext (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .iord(x_iord), .memwrite(x_memwrite), .irwrite(x_irwrite), .regdst(x_regdst),
      .memtoreg(x_memtoreg), .regwrite(x_regwrite), .alusrca(x_alusrca), .alusrcb(x_alusrcb),
      .pcsrc(x_pcsrc), .pcen(x_pcen), .alucontrol(x_alucontrol), .state(x_state));

   function automatic logic [2:0] fmap(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // expected outputs computed output-by-output from the set of states that assert each one
   function automatic logic [18:0] exp_vec(input logic [3:0] s, input logic r, input logic z,
                                           input logic [5:0] f);
      logic       pw;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      pw = (s == 4'd0) || (s == 4'd11);
      sb = s == 4'd0 ? 2'b01 : s == 4'd1 ? 2'b11 : (s == 4'd2 || s == 4'd9) ? 2'b10 : 2'b00;
      ps = s == 4'd8 ? 2'b01 : s == 4'd11 ? 2'b10 : 2'b00;
      ac = s == 4'd8 ? 3'b110 : s == 4'd6 ? fmap(f) : 3'b010;
      return {(s == 4'd3 || s == 4'd5), (s == 4'd5) & ~r, (s == 4'd0) & ~r, (s == 4'd7),
              (s == 4'd4), (s inside {4'd4, 4'd7, 4'd10}) & ~r, (s inside {4'd2, 4'd6, 4'd8, 4'd9}),
              sb, ps, ~r & (pw | ((s == 4'd8) & z)), ac, s};
   endfunction

   // model: each instruction is a fixed route of states after DECODE, chosen by op
   always @(posedge clk or posedge reset)
      if (reset) begin
         m_st = 4'd0;
         path.delete();
      end else if (m_st == 4'd0) m_st = 4'd1;
      else begin
         if (m_st == 4'd1)
            case (op)
               6'b100011: path = '{4'd2, 4'd3, 4'd4};
               6'b101011: path = '{4'd2, 4'd5};
               6'b000000: path = '{4'd6, 4'd7};
               6'b000100: path = '{4'd8};
               6'b001000: path = '{4'd9, 4'd10};
               6'b000010: path = '{4'd11};
               default:   path.delete();
            endcase
         m_st = path.size() > 0 ? path.pop_front() : 4'd0;
      end

   always @(negedge clk) begin
      logic [18:0] e, a;
      e = exp_vec(m_st, reset, zero, funct);
      a = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen,
           alucontrol, state};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL outputs t=%0t got %h want %h", $time, a, e);
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h", n, a, e);
      end
   endtask

   task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
      op = o;
      funct = f;
      zero = z;
      sh = 0; ah = 0; ph = 0; wh = 0; xh = 0; xw = 0;
      repeat (n) begin
         @(negedge clk);
         sh = {sh[27:0], state};
         ah = {ah[27:0], 1'b0, alucontrol};
         ph = {ph[30:0], pcen};
         wh = {wh[30:0], regwrite | memwrite};
         xh = {xh[27:0], x_state};
         xw = {xw[30:0], x_regwrite | x_memwrite};
         @(posedge clk);
         #1;
      end
   endtask

   logic [5:0] sweep_f[5] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
   logic [2:0] sweep_e[5] = '{3'b010, 3'b000, 3'b001, 3'b111, 3'b010};

   initial begin
      op = 6'd0;
      funct = 6'd0;
      zero = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", {state, irwrite, pcen, regwrite, memwrite, alusrcb, alucontrol},
          {4'h0, 4'b0000, 2'b01, 3'b010});
      reset = 1'b0;
      run(6'b100011, 6'd0, 1'b0, 5);
      chk("lw_states", sh, 32'h01234);
      run(6'b101011, 6'd0, 1'b0, 4);
      chk("sw_states", sh, 32'h0125);
      run(6'b000000, 6'b100010, 1'b0, 4);
      chk("rtype_states", sh, 32'h0167);
      chk("rtype_sub", ah[7:4], 32'h6);
      for (int i = 0; i < 5; i++) begin
         run(6'b000000, sweep_f[i], 1'b1, 4);
         chk("funct_sweep", ah[6:4], {29'd0, sweep_e[i]});
         chk("rtype_zero_no_pcen", ph[3:0], 32'b1000);
      end
      run(6'b000100, 6'd0, 1'b1, 3);
      chk("beq_states", sh, 32'h018);
      chk("beq_taken_pcen", ph[2:0], 32'b101);
      chk("beq_sub", ah[3:0], 32'h6);
      run(6'b000100, 6'd0, 1'b0, 3);
      chk("beq_not_taken_pcen", ph[2:0], 32'b100);
      run(6'b001000, 6'd0, 1'b0, 4);
      chk("addi_states", sh, 32'h019A);
      chk("noext_addi_states", xh, 32'h0101);
      chk("noext_addi_writes", xw[3:0], 32'h0);
      run(6'b000010, 6'd0, 1'b1, 3);
      chk("j_states", sh, 32'h01B);
      chk("j_pcen", ph[2:0], 32'b101);
      run(6'b111111, 6'd0, 1'b0, 2);
      chk("illegal_states", sh, 32'h01);
      chk("illegal_writes", wh[1:0], 32'h0);
      run(6'b100011, 6'd0, 1'b0, 3);
      chk("lw_in_memrd", {state, iord}, {4'h3, 1'b1});
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", {state, iord, irwrite, pcen, regwrite, memwrite}, {4'h0, 5'b00000});
      @(posedge clk);
      #1;
      chk("reset_held", {state, irwrite, pcen}, {4'h0, 2'b00});
      reset = 1'b0;
      run(6'b100011, 6'd0, 1'b0, 5);
      chk("lw_restart", sh, 32'h01234);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
